// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
//   FILL_EMPTY          fill count of an empty history
//   MODE_NONOVL/OVL     values of i_overlap
//   fill_phase_e        coarse fill FSM phase (empty / partial / full)
//   clog2()             ceiling log2, used to size counters
package seq_detect_pkg;

  localparam int unsigned FILL_EMPTY = 0;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  typedef enum logic [1:0] {
    FillEmpty,
    FillPartial,
    FillFull
  } fill_phase_e;

  // Smallest r with 2**r >= value (value >= 2 in all uses here).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches a single-cycle trigger into a level held for HOLD_CYCLES clocks.
// A new trigger while the level is high reloads the count, so back-to-back
// triggers give one continuous level.
//   i_clock  clock, rising edge
//   i_reset  synchronous, active-high reset
//   i_trig   trigger pulse
//   o_level  high while the stretch counter is non-zero
module pulse_stretch
  import seq_detect_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_trig,
  output logic o_level
);

  localparam int unsigned STRETCH_W = clog2(HOLD_CYCLES + 1);
  localparam logic [STRETCH_W-1:0] HOLD = STRETCH_W'(HOLD_CYCLES);

  logic [STRETCH_W-1:0] stretch_q, stretch_d;

  always_comb begin
    stretch_d = stretch_q;
    if (i_trig) begin
      stretch_d = HOLD;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stretch_q <= '0;
    end else begin
      stretch_q <= stretch_d;
    end
  end

  assign o_level = (stretch_q != '0);

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with runtime-loadable pattern,
// per-beat overlap selection, saturating match counter and stretched LED.
//   i_clock      clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_bit_valid  i_bit is a new beat this cycle
//   i_bit        serial data bit
//   i_pat_load   load i_pattern and flush history (same-cycle beat dropped)
//   i_pattern    new pattern, MSB is the oldest bit of the sequence
//   i_overlap    1 = overlapping detection, 0 = non-overlapping
//   o_match      registered 1-cycle pulse, one clock after the hit beat
//   o_led        high for HOLD_CYCLES clocks after the latest match
//   o_match_cnt  saturating match count
//   o_fill       number of valid history bits
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010,
  parameter int unsigned      CNT_W       = 8,
  parameter int unsigned      HOLD_CYCLES = 4,
  localparam int unsigned     FILL_W      = clog2(PAT_W + 1)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_bit_valid,
  input  logic              i_bit,
  input  logic              i_pat_load,
  input  logic [PAT_W-1:0]  i_pattern,
  input  logic              i_overlap,
  output logic              o_match,
  output logic              o_led,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic [FILL_W-1:0] o_fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_NONE = FILL_W'(FILL_EMPTY);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  fill_phase_e       phase;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // Fill FSM phase decode and saturating increment.
  always_comb begin
    if (fill_q == FILL_NONE) begin
      phase = FillEmpty;
    end else if (fill_q == FILL_FULL) begin
      phase = FillFull;
    end else begin
      phase = FillPartial;
    end

    fill_inc = fill_q;
    unique case (phase)
      FillEmpty:   fill_inc = FILL_W'(1);
      FillPartial: fill_inc = fill_q + 1'b1;
      FillFull:    fill_inc = FILL_FULL;
    endcase
  end

  always_comb begin
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    hit        = 1'b0;
    hist_shift = {hist_q[PAT_W-2:0], i_bit};

    if (i_pat_load) begin
      pat_d  = i_pattern;
      hist_d = '0;
      fill_d = FILL_NONE;
    end else if (i_bit_valid) begin
      hist_d = hist_shift;
      hit    = (fill_inc == FILL_FULL) && (hist_shift == pat_q);
      fill_d = fill_inc;
      // Non-overlapping mode restarts the count so the next match needs a
      // full pattern of fresh beats; overlapping keeps the suffix.
      if (hit && (i_overlap == MODE_NONOVL)) begin
        fill_d = FILL_NONE;
      end else if (hit && (i_overlap == MODE_OVL)) begin
        fill_d = FILL_FULL;
      end
    end

    match_d = hit;
    cnt_d   = (hit && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pat_q   <= DEFAULT_PAT;
      hist_q  <= '0;
      fill_q  <= FILL_NONE;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Triggered from the combinational hit so the LED rises together with o_match.
  pulse_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_led_stretch (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_trig (hit),
    .o_level(o_led)
  );

  assign o_match     = match_q;
  assign o_match_cnt = cnt_q;
  assign o_fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  localparam int PAT_W = 4;
  localparam int HOLD  = 4;

  logic       clk;
  logic       i_reset, i_bit_valid, i_bit, i_pat_load, i_overlap;
  logic [3:0] i_pattern;

  logic       a_match, a_led, b_match, b_led;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic [2:0] a_fill, b_fill;

  seq_detect_param #(
    .PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(8), .HOLD_CYCLES(4)
  ) u_dut (
    .i_clock(clk), .i_reset(i_reset), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_pat_load(i_pat_load), .i_pattern(i_pattern), .i_overlap(i_overlap),
    .o_match(a_match), .o_led(a_led), .o_match_cnt(a_cnt), .o_fill(a_fill)
  );

  seq_detect_param #(
    .PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(2), .HOLD_CYCLES(4)
  ) u_dut_sat (
    .i_clock(clk), .i_reset(i_reset), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_pat_load(i_pat_load), .i_pattern(i_pattern), .i_overlap(i_overlap),
    .o_match(b_match), .o_led(b_led), .o_match_cnt(b_cnt), .o_fill(b_fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       match;
    logic       led;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [2:0] fill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   led_hi   = 0;

  // Reference model: history kept as a list of received bits, oldest first.
  bit          mq[$];
  int unsigned m_pat;
  int          m_cnt8, m_cnt2, m_led;

  function automatic int unsigned hist_val();
    int unsigned v = 0;
    foreach (mq[i]) v = (v << 1) | int'(mq[i]);
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit b, input bit ld,
                            input logic [3:0] p, input bit ovl);
    bit   hit = 0;
    exp_t e;
    if (rst) begin
      mq.delete();
      m_pat  = 4'b1010;
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_led  = 0;
    end else begin
      if (ld) begin
        m_pat = p;
        mq.delete();
      end else if (v) begin
        mq.push_back(b);
        if (mq.size() > PAT_W) void'(mq.pop_front());
        if (mq.size() == PAT_W && hist_val() == m_pat) hit = 1;
        if (hit && !ovl) mq.delete();
      end
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        m_led = HOLD;
      end else if (m_led > 0) begin
        m_led--;
      end
    end
    e.match = hit;
    e.led   = (m_led != 0);
    e.cnt8  = 8'(m_cnt8);
    e.cnt2  = 2'(m_cnt2);
    e.fill  = 3'(mq.size());
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit v, input bit b, input bit ld,
                       input logic [3:0] p, input bit ovl);
    @(negedge clk);
    i_reset     = rst;
    i_bit_valid = v;
    i_bit       = b;
    i_pat_load  = ld;
    i_pattern   = p;
    i_overlap   = ovl;
    model_step(rst, v, b, ld, p, ovl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 4'h0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 4'h0, 0);
    drive(1, 0, 0, 0, 4'h0, 0);
  endtask

  task automatic beats(input logic [15:0] seq, input int n, input bit ovl);
    for (int i = n - 1; i >= 0; i--) drive(0, 1, seq[i], 0, 4'h0, ovl);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled shortly after each rising edge and compared
  // against the prediction pushed by the driver for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({a_match, a_led, a_cnt, a_fill} !== {e.match, e.led, e.cnt8, e.fill}) begin
          n_fail++;
          $display("FAIL dut8 @%0t: match/led/cnt/fill got %b/%b/%0d/%0d expected %b/%b/%0d/%0d",
                   $time, a_match, a_led, a_cnt, a_fill, e.match, e.led, e.cnt8, e.fill);
        end
        n_checks++;
        if ({b_match, b_led, b_cnt, b_fill} !== {e.match, e.led, e.cnt2, e.fill}) begin
          n_fail++;
          $display("FAIL dut2 @%0t: match/led/cnt/fill got %b/%b/%0d/%0d expected %b/%b/%0d/%0d",
                   $time, b_match, b_led, b_cnt, b_fill, e.match, e.led, e.cnt2, e.fill);
        end
        if (a_match === 1'b1) pulses++;
        if (a_led === 1'b1) led_hi++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0;
    i_reset = 1; i_bit_valid = 0; i_bit = 0; i_pat_load = 0; i_pattern = 0; i_overlap = 0;

    // 1: overlapping 101010 -> two matches
    do_reset();
    p0 = pulses;
    beats(16'b101010, 6, 1);
    idle(8);
    check_int("t1_pulses", pulses - p0, 2);
    check_int("t1_cnt", int'(a_cnt), 2);

    // 2: non-overlapping 10101010 -> matches after beats 4 and 8
    do_reset();
    p0 = pulses;
    beats(16'b10101010, 8, 0);
    idle(8);
    check_int("t2_pulses", pulses - p0, 2);
    check_int("t2_cnt", int'(a_cnt), 2);

    // 3: gapped beats, valid every third clock
    do_reset();
    p0 = pulses;
    for (int i = 3; i >= 0; i--) begin
      drive(0, 1, (4'b1010 >> i) & 1, 0, 4'h0, 1);
      idle(2);
    end
    idle(6);
    check_int("t3_pulses", pulses - p0, 1);

    // 4: load 0110 with a same-cycle beat, then new and old patterns
    do_reset();
    p0 = pulses;
    drive(0, 1, 1, 1, 4'b0110, 1);
    idle(1);
    check_int("t4_fill_after_load", int'(a_fill), 0);
    beats(16'b0110, 4, 1);
    idle(8);
    check_int("t4_new_pat_pulses", pulses - p0, 1);
    p0 = pulses;
    beats(16'b1010, 4, 0);
    idle(8);
    check_int("t4_old_pat_pulses", pulses - p0, 0);

    // 5: reset mid-sequence, then a full sequence; LED width
    do_reset();
    beats(16'b101, 3, 1);
    drive(1, 0, 0, 0, 4'h0, 1);
    p0 = pulses;
    l0 = led_hi;
    beats(16'b0, 1, 1);
    idle(1);
    check_int("t5_fill_after_reset", int'(a_fill), 1);
    beats(16'b1010, 4, 1);
    idle(8);
    check_int("t5_pulses", pulses - p0, 1);
    check_int("t5_led_cycles", led_hi - l0, HOLD);

    // 6: four overlapping hits: 2-bit counter saturates, LED stays high
    do_reset();
    p0 = pulses;
    l0 = led_hi;
    beats(16'b1010101010, 10, 1);
    idle(8);
    check_int("t6_pulses", pulses - p0, 4);
    check_int("t6_cnt_sat", int'(b_cnt), 3);
    check_int("t6_cnt_wide", int'(a_cnt), 4);
    check_int("t6_led_cycles", led_hi - l0, 10);

    // Random traffic
    do_reset();
    begin
      bit ovl = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(15) == 0) ovl = ~ovl;
        drive($urandom_range(199) == 0, $urandom_range(9) < 6, 1'($urandom),
              $urandom_range(39) == 0, 4'($urandom), ovl);
      end
    end
    idle(4);

    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_int("queue_drained", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
